gpr_commit_sched: RTL and testbench

- Multi-port commit scheduler for the difftest GPR-update path.
- Collects up to PORTS architectural register writebacks per cycle from the commit stage and buffers them in program order.
- Hands them one per cycle, via valid/ready, to the single-entry GPR update reporter.
- Filters x0 writes and flags lost commits so the golden-model comparison never silently diverges.

---
 rtl/gpr_commit_sched_if.sv | 45 ++++
 rtl/gpr_commit_sched.sv | 176 +++++++++++++++++
 tb/tb_gpr_commit_sched.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_commit_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : gpr_commit_sched_if                                            |
// | Purpose   : Commit-group input bus, single-entry output handshake and      |
// |             status lines of the GPR commit scheduler.                      |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface gpr_commit_sched_if #(
    parameter int PORTS      = 2,
    parameter int GPR_NUM    = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
);
    localparam int ID_W  = $clog2(GPR_NUM);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Commit-stage side: one slice per port, port 0 oldest
    logic [PORTS-1:0]            in_valid;
    logic [PORTS*ID_W-1:0]       in_id;
    logic [PORTS*DATA_WIDTH-1:0] in_wdata;
    logic                        in_ready;

    // Reporter side: one entry per cycle
    logic                        out_valid;
    logic [ID_W-1:0]             out_id;
    logic [DATA_WIDTH-1:0]       out_wdata;
    logic                        out_ready;

    // Status
    logic [CNT_W-1:0]            count;
    logic                        drop_err;

    // Environment: drives commits and the consumer ready
    modport master (
        output in_valid, in_id, in_wdata, out_ready,
        input  in_ready, out_valid, out_id, out_wdata, count, drop_err
    );

    // Scheduler
    modport slave (
        input  in_valid, in_id, in_wdata, out_ready,
        output in_ready, out_valid, out_id, out_wdata, count, drop_err
    );
endinterface
`default_nettype wire

// File: rtl/gpr_commit_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : gpr_commit_sched                                               |
// | Purpose   : Buffers up to PORTS GPR writebacks per cycle in program order  |
// |             and hands them one per cycle to the GPR update reporter.       |
// |             x0 writes are filtered; lost commits set a sticky flag.        |
// | Options   : GPR_COMMIT_SCHED_BYPASS_EN - zero-latency path when idle.      |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module gpr_commit_sched #(
    parameter int PORTS      = 2,
    parameter int GPR_NUM    = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,   // synchronous, active-low
    gpr_commit_sched_if.slave     bus
);
    localparam int ID_W  = $clog2(GPR_NUM);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int K_W   = $clog2(PORTS + 1);

    // A whole group fits only while at least PORTS entries are free
    localparam logic [CNT_W-1:0] FILL_LIMIT = CNT_W'(DEPTH - PORTS);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    // Storage (contents are don't-care after reset, so no reset on the array)
    logic [ID_W-1:0]       mem_id_q   [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic             drop_err_q, drop_err_d;

    // Per-port unpacked view of the commit group
    logic [ID_W-1:0]       port_id   [PORTS];
    logic [DATA_WIDTH-1:0] port_data [PORTS];
    logic [PORTS-1:0]      cand;

    // Compaction results
    logic [PORTS-1:0]      push;
    logic [PTR_W-1:0]      push_slot [PORTS];
    logic [K_W-1:0]        push_cnt;
    logic                  skip_pending;

    logic in_ready;
    logic accept;
    logic pop;
    logic bypass_take;

    // Slice the flat port buses and mark real (non-x0) writebacks
    generate
        for (genvar p = 0; p < PORTS; p++) begin : g_port
            assign port_id[p]   = bus.in_id[p*ID_W +: ID_W];
            assign port_data[p] = bus.in_wdata[p*DATA_WIDTH +: DATA_WIDTH];
            assign cand[p]      = bus.in_valid[p] && (port_id[p] != '0);
        end
    endgenerate

    // Readiness depends only on the registered occupancy
    assign in_ready = (count_q <= FILL_LIMIT);
    assign accept   = in_ready && rst;
    assign pop      = (count_q != '0) && bus.out_ready && rst;

`ifdef GPR_COMMIT_SCHED_BYPASS_EN
    logic                  any_cand;
    logic [ID_W-1:0]       first_id;
    logic [DATA_WIDTH-1:0] first_data;

    // Lowest-numbered candidate is the oldest and the one eligible to bypass
    always_comb begin
        any_cand   = |cand;
        first_id   = '0;
        first_data = '0;
        for (int p = PORTS - 1; p >= 0; p--) begin
            if (cand[p]) begin
                first_id   = port_id[p];
                first_data = port_data[p];
            end
        end
    end

    // The oldest candidate skips the buffer only when the buffer is empty
    // and the consumer takes it in this very cycle
    assign bypass_take = accept && (count_q == '0) && any_cand && bus.out_ready;
`else
    assign bypass_take = 1'b0;
`endif

    // Pack accepted candidates into consecutive slots starting at wr_ptr
    always_comb begin
        push         = '0;
        push_cnt     = '0;
        skip_pending = bypass_take;
        for (int p = 0; p < PORTS; p++) begin
            push_slot[p] = wr_ptr_q + PTR_W'(push_cnt);
            if (accept && cand[p]) begin
                if (skip_pending) begin
                    skip_pending = 1'b0;
                end else begin
                    push[p]  = 1'b1;
                    push_cnt = push_cnt + K_W'(1);
                end
            end
        end
    end

    // Next-state for pointers, occupancy and the sticky loss flag
    always_comb begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_cnt);
        count_d    = count_q + CNT_W'(push_cnt) - CNT_W'(pop);
        drop_err_d = drop_err_q || ((|bus.in_valid) && !in_ready);
    end

    // Control registers; reset flushes every pending entry
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            drop_err_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            drop_err_q <= drop_err_d;
        end
    end

    // Entry storage writes, one per enqueued candidate
    always_ff @(posedge clk) begin
        for (int p = 0; p < PORTS; p++) begin
            if (push[p]) begin
                mem_id_q[push_slot[p]]   <= port_id[p];
                mem_data_q[push_slot[p]] <= port_data[p];
            end
        end
    end

    // Head presentation: buffered head first, idle bypass second, else zeros
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_id    = '0;
        bus.out_wdata = '0;
        if (rst) begin
            if (count_q != '0) begin
                bus.out_valid = 1'b1;
                bus.out_id    = mem_id_q[rd_ptr_q];
                bus.out_wdata = mem_data_q[rd_ptr_q];
            end
`ifdef GPR_COMMIT_SCHED_BYPASS_EN
            else if (accept && any_cand) begin
                bus.out_valid = 1'b1;
                bus.out_id    = first_id;
                bus.out_wdata = first_data;
            end
`endif
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.count    = count_q;
    assign bus.drop_err = drop_err_q;

    // Occupancy must never exceed the buffer size
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (count_q <= FULL_COUNT);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_gpr_commit_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_gpr_commit_sched                                            |
// | Purpose   : Self-checking bench for gpr_commit_sched against a queue-based |
// |             reference model (honours GPR_COMMIT_SCHED_BYPASS_EN).          |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module tb_gpr_commit_sched;
    localparam int PORTS      = 2;
    localparam int GPR_NUM    = 32;
    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 8;
    localparam int ID_W       = $clog2(GPR_NUM);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gpr_commit_sched_if #(.PORTS(PORTS), .GPR_NUM(GPR_NUM),
                          .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) bus ();

    gpr_commit_sched #(.PORTS(PORTS), .GPR_NUM(GPR_NUM),
                       .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [ID_W-1:0]       id;
        logic [DATA_WIDTH-1:0] d;
    } ent_t;

    // Reference model: FIFO of pending entries plus sticky loss flag
    ent_t mq[$];
    ent_t cq[$];
    logic m_drop = 1'b0;

    // Expected outputs for the current cycle
    logic                  e_valid, e_ready, e_drop;
    logic [ID_W-1:0]       e_id;
    logic [DATA_WIDTH-1:0] e_data;
    logic [3:0]            e_count;

    task automatic drive(input logic [1:0] v, input logic [4:0] id0, input logic [31:0] d0,
                         input logic [4:0] id1, input logic [31:0] d1);
        bus.in_valid = v;
        bus.in_id    = {id1, id0};
        bus.in_wdata = {d1, d0};
    endtask

    // Gather the current group's real writebacks, oldest port first
    task automatic collect();
        cq.delete();
        for (int p = 0; p < PORTS; p++) begin
            if (bus.in_valid[p] && bus.in_id[p*ID_W +: ID_W] != '0)
                cq.push_back({bus.in_id[p*ID_W +: ID_W], bus.in_wdata[p*DATA_WIDTH +: DATA_WIDTH]});
        end
    endtask

    task automatic predict();
        collect();
        e_count = 4'(mq.size());
        e_ready = (DEPTH - mq.size()) >= PORTS;
        e_drop  = m_drop;
        e_valid = 1'b0;
        e_id    = '0;
        e_data  = '0;
        if (rst) begin
            if (mq.size() != 0) begin
                e_valid = 1'b1;
                e_id    = mq[0].id;
                e_data  = mq[0].d;
            end
`ifdef GPR_COMMIT_SCHED_BYPASS_EN
            else if (cq.size() != 0) begin
                e_valid = 1'b1;
                e_id    = cq[0].id;
                e_data  = cq[0].d;
            end
`endif
        end
    endtask

    // Apply one clock edge to the model using the inputs present at that edge
    task automatic commit();
        bit room;
        bit byp;
        collect();
        if (!rst) begin
            mq.delete();
            m_drop = 1'b0;
            return;
        end
        room = (DEPTH - mq.size()) >= PORTS;
        byp  = 1'b0;
`ifdef GPR_COMMIT_SCHED_BYPASS_EN
        byp  = (mq.size() == 0) && (cq.size() != 0) && bus.out_ready;
`endif
        if (mq.size() != 0 && bus.out_ready) void'(mq.pop_front());
        if (room) begin
            for (int i = 0; i < cq.size(); i++)
                if (!(byp && i == 0)) mq.push_back(cq[i]);
        end else if (|bus.in_valid) begin
            m_drop = 1'b1;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        predict();
    endtask

    task automatic tick();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(2'b00, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        drive(2'b11, 5'd4, 32'hAAAA0001, 5'd6, 32'hAAAA0002);
        tick();
        for (int c = 0; c < 4; c++) begin
            if (c == 2) begin
                rst = 1'b1;
                drive(2'b00, 0, 0, 0, 0);
            end
            sample();
            checks++;
            if ({bus.out_valid, bus.out_id, bus.out_wdata, bus.count, bus.drop_err} !==
                {1'b0, 5'd0, 32'd0, 4'd0, 1'b0}) begin
                errors++;
                $display("FAIL reset c=%0d: got v=%b id=%0d d=%h cnt=%0d drop=%b, expected all zero",
                         c, bus.out_valid, bus.out_id, bus.out_wdata, bus.count, bus.drop_err);
            end
            tick();
        end
    endtask

    task automatic test_dual_commit();
        logic [4:0]  seen_id[$];
        logic [31:0] seen_d[$];
        do_reset();
        bus.out_ready = 1'b1;
        drive(2'b11, 5'd5, 32'h11111111, 5'd7, 32'h22222222);
        for (int c = 0; c < 5; c++) begin
            sample();
            if (bus.out_valid && bus.out_ready) begin
                seen_id.push_back(bus.out_id);
                seen_d.push_back(bus.out_wdata);
            end
            checks++;
            if ({bus.out_valid, bus.out_id, bus.out_wdata, bus.count, bus.in_ready, bus.drop_err} !==
                {e_valid, e_id, e_data, e_count, e_ready, e_drop}) begin
                errors++;
                $display("FAIL dual c=%0d: got v=%b id=%0d d=%h cnt=%0d rdy=%b drop=%b, expected v=%b id=%0d d=%h cnt=%0d rdy=%b drop=%b",
                         c, bus.out_valid, bus.out_id, bus.out_wdata, bus.count, bus.in_ready, bus.drop_err,
                         e_valid, e_id, e_data, e_count, e_ready, e_drop);
            end
            tick();
            drive(2'b00, 0, 0, 0, 0);
        end
        checks++;
        if (seen_id.size() != 2 || seen_id[0] !== 5'd5 || seen_id[1] !== 5'd7 ||
            seen_d[0] !== 32'h11111111 || seen_d[1] !== 32'h22222222) begin
            errors++;
            $display("FAIL dual_order: got %0d entries, expected id5/11111111 then id7/22222222", seen_id.size());
        end
    endtask

    task automatic test_x0_filter();
        logic [4:0]  seen_id[$];
        logic [31:0] seen_d[$];
        int          peak;
        do_reset();
        peak = 0;
        bus.out_ready = 1'b1;
        drive(2'b11, 5'd0, 32'h0000DEAD, 5'd3, 32'h0000BEEF);
        for (int c = 0; c < 4; c++) begin
            sample();
            if (bus.out_valid && bus.out_ready) begin
                seen_id.push_back(bus.out_id);
                seen_d.push_back(bus.out_wdata);
            end
            if (int'(bus.count) > peak) peak = int'(bus.count);
            checks++;
            if ({bus.out_valid, bus.out_id, bus.out_wdata, bus.count, bus.in_ready, bus.drop_err} !==
                {e_valid, e_id, e_data, e_count, e_ready, e_drop}) begin
                errors++;
                $display("FAIL x0 c=%0d: got v=%b id=%0d d=%h cnt=%0d rdy=%b drop=%b, expected v=%b id=%0d d=%h cnt=%0d rdy=%b drop=%b",
                         c, bus.out_valid, bus.out_id, bus.out_wdata, bus.count, bus.in_ready, bus.drop_err,
                         e_valid, e_id, e_data, e_count, e_ready, e_drop);
            end
            tick();
            drive(2'b00, 0, 0, 0, 0);
        end
        checks++;
        if (seen_id.size() != 1 || seen_id[0] !== 5'd3 || seen_d[0] !== 32'h0000BEEF || peak > 1) begin
            errors++;
            $display("FAIL x0_single: got %0d entries peak=%0d, expected one id3/0000BEEF peak<=1",
                     seen_id.size(), peak);
        end
    endtask

    task automatic test_backpressure_full();
        do_reset();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 17; c++) begin
            if (c < 5)
                drive(2'b11, 5'($urandom_range(1, 31)), $urandom, 5'($urandom_range(1, 31)), $urandom);
            else
                drive(2'b00, 0, 0, 0, 0);
            if (c == 7) bus.out_ready = 1'b1;
            sample();
            if (c == 5) begin
                checks++;
                if (bus.count !== 4'd8 || bus.in_ready !== 1'b0 || bus.drop_err !== 1'b1) begin
                    errors++;
                    $display("FAIL full: got cnt=%0d rdy=%b drop=%b, expected cnt=8 rdy=0 drop=1",
                             bus.count, bus.in_ready, bus.drop_err);
                end
            end
            checks++;
            if ({bus.out_valid, bus.out_id, bus.out_wdata, bus.count, bus.in_ready, bus.drop_err} !==
                {e_valid, e_id, e_data, e_count, e_ready, e_drop}) begin
                errors++;
                $display("FAIL backpressure c=%0d: got v=%b id=%0d d=%h cnt=%0d rdy=%b drop=%b, expected v=%b id=%0d d=%h cnt=%0d rdy=%b drop=%b",
                         c, bus.out_valid, bus.out_id, bus.out_wdata, bus.count, bus.in_ready, bus.drop_err,
                         e_valid, e_id, e_data, e_count, e_ready, e_drop);
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 34; c++) begin
            if (c < 20 && (DEPTH - mq.size()) >= PORTS)
                drive(2'b11, 5'($urandom_range(1, 31)), $urandom, 5'($urandom_range(1, 31)), $urandom);
            else
                drive(2'b00, 0, 0, 0, 0);
            sample();
            checks++;
            if ({bus.out_valid, bus.out_id, bus.out_wdata, bus.count, bus.in_ready, bus.drop_err} !==
                {e_valid, e_id, e_data, e_count, e_ready, e_drop}) begin
                errors++;
                $display("FAIL wrap c=%0d: got v=%b id=%0d d=%h cnt=%0d rdy=%b drop=%b, expected v=%b id=%0d d=%h cnt=%0d rdy=%b drop=%b",
                         c, bus.out_valid, bus.out_id, bus.out_wdata, bus.count, bus.in_ready, bus.drop_err,
                         e_valid, e_id, e_data, e_count, e_ready, e_drop);
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            rst = ($urandom_range(0, 59) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            drive(2'($urandom), 5'($urandom), $urandom, 5'($urandom), $urandom);
            sample();
            checks++;
            if ({bus.out_valid, bus.out_id, bus.out_wdata, bus.count, bus.in_ready, bus.drop_err} !==
                {e_valid, e_id, e_data, e_count, e_ready, e_drop}) begin
                errors++;
                $display("FAIL random c=%0d: got v=%b id=%0d d=%h cnt=%0d rdy=%b drop=%b, expected v=%b id=%0d d=%h cnt=%0d rdy=%b drop=%b",
                         c, bus.out_valid, bus.out_id, bus.out_wdata, bus.count, bus.in_ready, bus.drop_err,
                         e_valid, e_id, e_data, e_count, e_ready, e_drop);
            end
            tick();
        end
        rst = 1'b1;
    endtask

    task automatic test_bypass();
        logic       exp_now_v, exp_next_v;
        logic [3:0] exp_next_cnt;
`ifdef GPR_COMMIT_SCHED_BYPASS_EN
        exp_now_v = 1'b1; exp_next_v = 1'b0; exp_next_cnt = 4'd0;
`else
        exp_now_v = 1'b0; exp_next_v = 1'b1; exp_next_cnt = 4'd1;
`endif
        do_reset();
        bus.out_ready = 1'b1;
        drive(2'b01, 5'd9, 32'h9, 5'd0, 32'h0);
        sample();
        checks++;
        if (bus.out_valid !== exp_now_v || (exp_now_v && (bus.out_id !== 5'd9 || bus.out_wdata !== 32'h9))) begin
            errors++;
            $display("FAIL bypass_same: got v=%b id=%0d d=%h, expected v=%b id=9",
                     bus.out_valid, bus.out_id, bus.out_wdata, exp_now_v);
        end
        tick();
        drive(2'b00, 0, 0, 0, 0);
        bus.out_ready = 1'b0;
        sample();
        checks++;
        if (bus.out_valid !== exp_next_v || bus.count !== exp_next_cnt ||
            (exp_next_v && bus.out_id !== 5'd9)) begin
            errors++;
            $display("FAIL bypass_next: got v=%b id=%0d cnt=%0d, expected v=%b cnt=%0d",
                     bus.out_valid, bus.out_id, bus.count, exp_next_v, exp_next_cnt);
        end
        tick();
    endtask

    initial begin
        bus.out_ready = 1'b0;
        drive(2'b00, 0, 0, 0, 0);
        test_reset();
        test_dual_commit();
        test_x0_filter();
        test_backpressure_full();
        test_wrap();
        test_random();
        test_bypass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
